heap_mem_responder: RTL and testbench

//  Responder end of the NockPU memory request protocol driven by memory_mux
//  (func/execute/address1/address2/write_data -> read_data1/read_data2/is_ready/free_addr).

---
 rtl/heap_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_heap_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_mem_responder.sv
// Single-port heap RAM responder for the NockPU memory request protocol.
// Serialises dual reads, performs writes and bump-pointer allocation, tracks the free pointer.
module heap_mem_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int FREE_BASE = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic [1:0]        func,
    input  logic              execute,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] free_addr,
    output logic              is_ready,
    output logic              oom
);

    localparam logic [1:0] FUNC_READ2 = 2'b00;
    localparam logic [1:0] FUNC_WRITE = 2'b01;
    localparam logic [1:0] FUNC_ALLOC = 2'b10;
    localparam logic [1:0] FUNC_READ1 = 2'b11;

    localparam logic [ADDR_W-1:0] FREE_BASE_C = ADDR_W'(FREE_BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_RD_C = 3'd3,
        ST_WR   = 3'd4
    } state_t;

    state_t              state_r;
    logic [1:0]          func_r;
    logic [ADDR_W-1:0]   addr1_r;
    logic [ADDR_W-1:0]   addr2_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rd1_r;
    logic [DATA_W-1:0]   rd2_r;
    logic [ADDR_W-1:0]   free_addr_r;
    logic                is_ready_r;
    logic                oom_r;

    logic [DATA_W-1:0]   mem_r [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0]   ram_q_r;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic                ram_we_s;

    // Single RAM port: address selection and write enable from the current state.
    always_comb begin
        ram_addr_s = addr1_r;
        ram_we_s   = 1'b0;
        case (state_r)
            ST_RD_A: ram_addr_s = addr1_r;
            ST_RD_B: ram_addr_s = addr2_r;
            ST_WR: begin
                if (func_r == FUNC_WRITE) begin
                    ram_addr_s = addr1_r;
                    ram_we_s   = 1'b1;
                end else if (func_r == FUNC_ALLOC) begin
                    ram_addr_s = free_addr_r;
                    ram_we_s   = ~oom_r;
                end else begin
                    ram_we_s   = 1'b0;
                end
            end
            default: ram_addr_s = addr1_r;
        endcase
    end

    // RAM array with registered read; frozen while powered down or in reset so aborts never write.
    always_ff @(posedge clk) begin
        if (power && !rst) begin
            if (ram_we_s) begin
                mem_r[ram_addr_s] <= wdata_r;
            end
            ram_q_r <= mem_r[ram_addr_s];
        end
    end

    // Request FSM: accept/latch, serialised read capture, write/alloc completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            func_r      <= FUNC_READ2;
            addr1_r     <= {ADDR_W{1'b0}};
            addr2_r     <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            rd1_r       <= {DATA_W{1'b0}};
            rd2_r       <= {DATA_W{1'b0}};
            free_addr_r <= FREE_BASE_C;
            is_ready_r  <= 1'b0;
            oom_r       <= 1'b0;
        end else if (power) begin
            case (state_r)
                ST_IDLE: begin
                    if (!is_ready_r) begin
                        is_ready_r <= 1'b1;
                    end else if (execute) begin
                        func_r     <= func;
                        addr1_r    <= address1;
                        addr2_r    <= address2;
                        wdata_r    <= write_data;
                        is_ready_r <= 1'b0;
                        case (func)
                            FUNC_READ2, FUNC_READ1: state_r <= ST_RD_A;
                            FUNC_WRITE, FUNC_ALLOC: state_r <= ST_WR;
                            default:                state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RD_A: state_r <= ST_RD_B;
                ST_RD_B: begin
                    rd1_r <= ram_q_r;
                    if (func_r == FUNC_READ1) begin
                        state_r    <= ST_IDLE;
                        is_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_RD_C;
                    end
                end
                ST_RD_C: begin
                    rd2_r      <= ram_q_r;
                    state_r    <= ST_IDLE;
                    is_ready_r <= 1'b1;
                end
                ST_WR: begin
                    // The top word is still written on exhaustion; the pointer just stops there.
                    if (func_r == FUNC_ALLOC && !oom_r) begin
                        if (free_addr_r == LAST_ADDR_C) begin
                            oom_r <= 1'b1;
                        end else begin
                            free_addr_r <= free_addr_r + ADDR_ONE_C;
                        end
                    end
                    state_r    <= ST_IDLE;
                    is_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    is_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign read_data1 = rd1_r;
    assign read_data2 = rd2_r;
    assign free_addr  = free_addr_r;
    assign is_ready   = is_ready_r;
    assign oom        = oom_r;

endmodule

// File: tb/tb_heap_mem_responder.sv
// Bench for heap_mem_responder: directed scenarios plus randomized traffic against a
// transaction-level model (latency countdown, plain memory array, free pointer).
module tb_heap_mem_responder;

    localparam int AW = 10;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          power = 1'b1;
    logic          execute = 1'b0;
    logic [1:0]    func = 2'b00;
    logic [AW-1:0] address1 = '0;
    logic [AW-1:0] address2 = '0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [AW-1:0] free_addr;
    logic          is_ready;
    logic          oom;

    heap_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .FREE_BASE(256)) dut (
        .clk(clk), .rst(rst), .power(power), .func(func), .execute(execute),
        .address1(address1), .address2(address2), .write_data(write_data),
        .read_data1(read_data1), .read_data2(read_data2), .free_addr(free_addr),
        .is_ready(is_ready), .oom(oom)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: what each output must be, derived from the request rules only.
    logic [DW-1:0] m_mem [1024];
    bit            m_valid [1024];
    logic [DW-1:0] m_rd1, m_rd2;
    bit            m_k1, m_k2;
    int            m_free;
    bit            m_oom, m_ready, m_accepted;
    int            m_busy;
    logic [1:0]    m_f;
    int            m_a1, m_a2;
    logic [DW-1:0] m_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int latency(input logic [1:0] f);
        case (f)
            2'b00:   return 3;
            2'b11:   return 2;
            default: return 1;
        endcase
    endfunction

    task automatic complete_op();
        case (m_f)
            2'b00: begin
                m_rd1 = m_mem[m_a1]; m_k1 = m_valid[m_a1];
                m_rd2 = m_mem[m_a2]; m_k2 = m_valid[m_a2];
            end
            2'b11: begin
                m_rd1 = m_mem[m_a1]; m_k1 = m_valid[m_a1];
            end
            2'b01: begin
                m_mem[m_a1] = m_d; m_valid[m_a1] = 1'b1;
            end
            default: begin
                if (!m_oom) begin
                    m_mem[m_free] = m_d; m_valid[m_free] = 1'b1;
                    if (m_free == 1023) m_oom = 1'b1;
                    else m_free = m_free + 1;
                end
            end
        endcase
    endtask

    task automatic model_step();
        m_accepted = 1'b0;
        if (rst) begin
            m_ready = 1'b0; m_busy = 0; m_rd1 = '0; m_rd2 = '0;
            m_k1 = 1'b1; m_k2 = 1'b1; m_free = 256; m_oom = 1'b0;
        end else if (power) begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    complete_op();
                    m_ready = 1'b1;
                end
            end else if (!m_ready) begin
                m_ready = 1'b1;
            end else if (execute) begin
                m_f = func; m_a1 = int'(address1); m_a2 = int'(address2); m_d = write_data;
                m_busy = latency(func); m_ready = 1'b0; m_accepted = 1'b1;
            end
        end
    endtask

    task automatic compare();
        check("is_ready", 64'(is_ready), 64'(m_ready));
        check("free_addr", 64'(free_addr), 64'(m_free));
        check("oom", 64'(oom), 64'(m_oom));
        if (m_ready && m_k1) check("read_data1", read_data1, m_rd1);
        if (m_ready && m_k2) check("read_data2", read_data2, m_rd2);
    endtask

    // One clock: inputs already stable, model follows the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_op(input logic [1:0] f, input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                         input logic [DW-1:0] d, output int lat);
        bit acc;
        bit done;
        func = f; address1 = x1; address2 = x2; write_data = d; execute = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            tick();
            acc = m_accepted;
        end
        check("accept_timeout", 64'(acc), 64'd1);
        execute = 1'b0;
        address1 = AW'($urandom); address2 = AW'($urandom); write_data = {$urandom, $urandom};
        lat = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            lat++;
            done = is_ready;
        end
        check("op_done_timeout", 64'(done), 64'd1);
    endtask

    int lat;

    initial begin
        // Reset held for two edges, then released.
        tick();
        check("rst_ready_low0", 64'(is_ready), 64'd0);
        tick();
        check("rst_ready_low1", 64'(is_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_ready_high", 64'(is_ready), 64'd1);
        check("rst_free", 64'(free_addr), 64'd256);
        check("rst_oom", 64'(oom), 64'd0);
        check("rst_rd1", read_data1, 64'd0);
        check("rst_rd2", read_data2, 64'd0);

        do_op(2'b01, 10'd5, 10'd0, 64'hDEAD, lat);
        check("write_latency", 64'(lat), 64'd1);
        do_op(2'b00, 10'd5, 10'd5, 64'h0, lat);
        check("read2_latency", 64'(lat), 64'd3);
        check("read2_same_d1", read_data1, 64'hDEAD);
        check("read2_same_d2", read_data2, 64'hDEAD);

        do_op(2'b10, 10'd0, 10'd0, 64'h11, lat);
        check("alloc_free_257", 64'(free_addr), 64'd257);
        do_op(2'b10, 10'd0, 10'd0, 64'h22, lat);
        check("alloc_free_258", 64'(free_addr), 64'd258);
        do_op(2'b00, 10'd256, 10'd257, 64'h0, lat);
        check("alloc_rd_256", read_data1, 64'h11);
        check("alloc_rd_257", read_data2, 64'h22);
        do_op(2'b11, 10'd257, 10'd5, 64'h0, lat);
        check("read1_latency", 64'(lat), 64'd2);
        check("read1_d1", read_data1, 64'h22);
        check("read1_keeps_d2", read_data2, 64'h22);

        for (int a = 0; a < 32; a++) begin
            do_op(2'b01, AW'(a), 10'd0, {$urandom, $urandom}, lat);
        end

        // Randomized traffic: the model reacts to whatever inputs each edge sees.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            power      = ($urandom_range(0, 7) != 0);
            execute    = $urandom_range(0, 1) == 1;
            func       = 2'($urandom);
            address1   = AW'($urandom_range(0, 31));
            address2   = ($urandom_range(0, 3) == 0) ? AW'(256 + $urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            write_data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0; power = 1'b1; execute = 1'b0;
        for (int i = 0; i < 10 && !is_ready; i++) tick();

        // Reset while the READ2 sits in its second-address state.
        do_op(2'b01, 10'd9, 10'd0, 64'h1234, lat);
        func = 2'b00; address1 = 10'd9; address2 = 10'd9; execute = 1'b1;
        tick();
        execute = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_rd2_zero", read_data2, 64'd0);
        check("abort_ready_low", 64'(is_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("abort_ready_next", 64'(is_ready), 64'd1);

        // Power drop for four cycles in the middle of a WRITE.
        func = 2'b01; address1 = 10'd7; write_data = 64'hBEEF; execute = 1'b1;
        tick();
        execute = 1'b0;
        power = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pwr_hold_ready", 64'(is_ready), 64'd0);
        power = 1'b1;
        tick();
        check("pwr_resume_ready", 64'(is_ready), 64'd1);
        do_op(2'b11, 10'd7, 10'd0, 64'h0, lat);
        check("pwr_write_data", read_data1, 64'hBEEF);

        // Back-to-back WRITEs with execute held high.
        func = 2'b01; address1 = 10'd3; write_data = 64'h3333; execute = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        execute = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Heap exhaustion.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 767; i++) do_op(2'b10, 10'd0, 10'd0, 64'(i), lat);
        check("exh_free_1023", 64'(free_addr), 64'd1023);
        check("exh_oom_clear", 64'(oom), 64'd0);
        do_op(2'b10, 10'd0, 10'd0, 64'hA110C, lat);
        check("exh_oom_set", 64'(oom), 64'd1);
        check("exh_free_hold", 64'(free_addr), 64'd1023);
        do_op(2'b10, 10'd0, 10'd0, 64'hBAD, lat);
        check("exh_late_latency", 64'(lat), 64'd1);
        check("exh_oom_sticky", 64'(oom), 64'd1);
        do_op(2'b00, 10'd1023, 10'd1022, 64'h0, lat);
        check("exh_top_word", read_data1, 64'hA110C);
        check("exh_prev_word", read_data2, 64'd766);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
